// File: rtl/uart_cmd_ctrl.sv
// UART command framer: A5 | op | len | payload[len] | (csum when UART_CMD_CHECKSUM_EN) -> one command.
// Latency: cmd_valid rises the cycle after the final frame byte; errors pulse the cycle after the cause.
// Backpressure: command held until cmd_valid&&cmd_ready; bytes arriving while held are dropped (OVERRUN).
module uart_cmd_ctrl #(
    parameter int TIMEOUT = 95000,
    parameter int MAX_LEN = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [7:0]  cmd_op,
    output logic [31:0] cmd_arg,
    output logic [2:0]  cmd_len,
    output logic        err_pulse,
    output logic [1:0]  err_code
);

    localparam int         GAP_W = $clog2(TIMEOUT + 1);
    localparam logic [7:0] SYNC  = 8'hA5;

    localparam logic [1:0] ERR_TIMEOUT = 2'd0;
    localparam logic [1:0] ERR_BADLEN  = 2'd1;
    localparam logic [1:0] ERR_OVERRUN = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_OP   = 3'd1,
        S_LEN  = 3'd2,
        S_PAY  = 3'd3,
`ifdef UART_CMD_CHECKSUM_EN
        S_CSUM = 3'd4,
`endif
        S_HOLD = 3'd5
    } state_t;

`ifdef UART_CMD_CHECKSUM_EN
    localparam logic [1:0] ERR_CSUM = 2'd2;
    localparam state_t     S_TAIL   = S_CSUM;
    logic [7:0]            r_csum;
`else
    localparam state_t     S_TAIL   = S_HOLD;
`endif

    state_t             r_state;
    state_t             w_state_nxt;
    logic [7:0]         r_op;
    logic [31:0]        r_arg;
    logic [2:0]         r_len;
    logic [1:0]         r_idx;
    logic [GAP_W-1:0]   r_gap;
    logic               r_err_pulse;
    logic [1:0]         r_err_code;
    logic               w_err;
    logic [1:0]         w_err_code;
    logic               w_active;
    logic               w_timeout;
    logic               w_len_ok;
    logic               w_pay_last;

    assign w_active   = (r_state == S_OP) || (r_state == S_LEN) || (r_state == S_PAY)
`ifdef UART_CMD_CHECKSUM_EN
                        || (r_state == S_CSUM)
`endif
                        ;
    // Fires on the edge where the idle gap would reach TIMEOUT cycles.
    assign w_timeout  = w_active && !rx_valid && (r_gap == GAP_W'(TIMEOUT - 1));
    assign w_len_ok   = (rx_data <= 8'(MAX_LEN));
    assign w_pay_last = (({1'b0, r_idx} + 3'd1) == r_len);

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_err       = 1'b0;
        w_err_code  = ERR_TIMEOUT;
        case (r_state)
            S_IDLE: if (rx_valid && rx_data == SYNC) w_state_nxt = S_OP;
            S_OP: begin
                if (rx_valid) w_state_nxt = S_LEN;
                else if (w_timeout) begin w_state_nxt = S_IDLE; w_err = 1'b1; end
            end
            S_LEN: begin
                if (rx_valid) begin
                    if (!w_len_ok) begin
                        w_state_nxt = S_IDLE;
                        w_err       = 1'b1;
                        w_err_code  = ERR_BADLEN;
                    end else if (rx_data != 8'd0) w_state_nxt = S_PAY;
                    else                          w_state_nxt = S_TAIL;
                end else if (w_timeout) begin w_state_nxt = S_IDLE; w_err = 1'b1; end
            end
            S_PAY: begin
                if (rx_valid) begin
                    if (w_pay_last) w_state_nxt = S_TAIL;
                end else if (w_timeout) begin w_state_nxt = S_IDLE; w_err = 1'b1; end
            end
`ifdef UART_CMD_CHECKSUM_EN
            S_CSUM: begin
                if (rx_valid) begin
                    if (rx_data == r_csum) w_state_nxt = S_HOLD;
                    else begin
                        w_state_nxt = S_IDLE;
                        w_err       = 1'b1;
                        w_err_code  = ERR_CSUM;
                    end
                end else if (w_timeout) begin w_state_nxt = S_IDLE; w_err = 1'b1; end
            end
`endif
            S_HOLD: begin
                // A byte landing on the transfer cycle is treated as if already idle.
                if (cmd_ready) w_state_nxt = (rx_valid && rx_data == SYNC) ? S_OP : S_IDLE;
                else if (rx_valid) begin
                    w_err      = 1'b1;
                    w_err_code = ERR_OVERRUN;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op        <= 8'd0;
            r_arg       <= 32'd0;
            r_len       <= 3'd0;
            r_idx       <= 2'd0;
            r_gap       <= '0;
            r_err_pulse <= 1'b0;
            r_err_code  <= 2'd0;
`ifdef UART_CMD_CHECKSUM_EN
            r_csum      <= 8'd0;
`endif
        end else begin
            r_err_pulse <= w_err;
            if (w_err) r_err_code <= w_err_code;

            if (rx_valid || !w_active || w_timeout) r_gap <= '0;
            else                                     r_gap <= r_gap + 1'b1;

            if (rx_valid) begin
                case (r_state)
                    S_OP: begin
                        r_op <= rx_data;
`ifdef UART_CMD_CHECKSUM_EN
                        r_csum <= rx_data;
`endif
                    end
                    S_LEN: begin
                        if (w_len_ok) begin
                            r_len <= rx_data[2:0];
                            r_arg <= 32'd0;
                            r_idx <= 2'd0;
`ifdef UART_CMD_CHECKSUM_EN
                            r_csum <= r_csum ^ rx_data;
`endif
                        end
                    end
                    S_PAY: begin
                        r_arg[{r_idx, 3'b000} +: 8] <= rx_data;
                        r_idx <= r_idx + 2'd1;
`ifdef UART_CMD_CHECKSUM_EN
                        r_csum <= r_csum ^ rx_data;
`endif
                    end
                    default: ;
                endcase
            end
        end
    end

    assign cmd_valid = (r_state == S_HOLD);
    assign cmd_op    = r_op;
    assign cmd_arg   = r_arg;
    assign cmd_len   = r_len;
    assign err_pulse = r_err_pulse;
    assign err_code  = r_err_code;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Scoreboard bench for uart_cmd_ctrl: expected commands/errors queued at stimulus, checked on output.
module tb_uart_cmd_ctrl;

    localparam int TIMEOUT = 20;
    localparam int MAX_LEN = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'd0;
    logic        cmd_valid;
    logic        cmd_ready = 1'b1;
    logic [7:0]  cmd_op;
    logic [31:0] cmd_arg;
    logic [2:0]  cmd_len;
    logic        err_pulse;
    logic [1:0]  err_code;

    typedef struct {
        logic [7:0]  op;
        logic [2:0]  len;
        logic [31:0] arg;
    } cmd_t;

    cmd_t       exp_cmd[$];
    logic [1:0] exp_err[$];
    int         n_chk  = 0;
    int         n_fail = 0;

    uart_cmd_ctrl #(.TIMEOUT(TIMEOUT), .MAX_LEN(MAX_LEN)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_arg   (cmd_arg),
        .cmd_len   (cmd_len),
        .err_pulse (err_pulse),
        .err_code  (err_code)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Output side of the scoreboard: every error strobe and every transfer pops one entry.
    always @(negedge clk) begin
        if (!rst) begin
            if (err_pulse) begin
                if (exp_err.size() == 0) chk("err_unexpected", 32'd1, 32'd0);
                else                     chk("err_code", {30'd0, err_code}, {30'd0, exp_err.pop_front()});
            end
            if (cmd_valid && cmd_ready) begin
                if (exp_cmd.size() == 0) chk("cmd_unexpected", 32'd1, 32'd0);
                else begin
                    cmd_t c;
                    c = exp_cmd.pop_front();
                    chk("cmd_op",  {24'd0, cmd_op},  {24'd0, c.op});
                    chk("cmd_len", {29'd0, cmd_len}, {29'd0, c.len});
                    chk("cmd_arg", cmd_arg, c.arg);
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    // Sends op, len, payload (and checksum when enabled); expects a command one cycle later.
    task automatic send_body(input logic [7:0] op, input logic [2:0] len, input logic [31:0] arg);
        cmd_t       c;
        logic [7:0] cs;
        c.op = op; c.len = len; c.arg = arg;
        exp_cmd.push_back(c);
        cs = op ^ {5'd0, len};
        send_byte(op);
        send_byte({5'd0, len});
        for (int i = 0; i < int'(len); i++) begin
            cs = cs ^ arg[8*i +: 8];
            send_byte(arg[8*i +: 8]);
        end
`ifdef UART_CMD_CHECKSUM_EN
        send_byte(cs);
`endif
        chk("latency_vld", {31'd0, cmd_valid}, 32'd1);
    endtask

    task automatic send_frame(input logic [7:0] op, input logic [2:0] len, input logic [31:0] arg);
        send_byte(8'hA5);
        send_body(op, len, arg);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int  n_to;
        bit  seen;

        idle(3);
        chk("rst_vld",  {31'd0, cmd_valid}, 32'd0);
        chk("rst_op",   {24'd0, cmd_op},    32'd0);
        chk("rst_arg",  cmd_arg,            32'd0);
        chk("rst_len",  {29'd0, cmd_len},   32'd0);
        chk("rst_err",  {31'd0, err_pulse}, 32'd0);
        chk("rst_code", {30'd0, err_code},  32'd0);
        rst = 1'b0;
        idle(2);

        send_frame(8'h10, 3'd2, 32'h0000_1234);
        idle(2);

        // Noise in IDLE is ignored without error.
        send_byte(8'h00); send_byte(8'hFF); send_byte(8'h13);
        idle(2);

        exp_err.push_back(2'd1);
        send_byte(8'hA5); send_byte(8'h20); send_byte(8'h05);
        chk("badlen_pulse", {31'd0, err_pulse}, 32'd1);
        idle(3);
        chk("badlen_novld", {31'd0, cmd_valid}, 32'd0);

`ifdef UART_CMD_CHECKSUM_EN
        exp_err.push_back(2'd2);
        send_byte(8'hA5); send_byte(8'h10); send_byte(8'h01); send_byte(8'hFF); send_byte(8'h00);
        chk("csum_pulse", {31'd0, err_pulse}, 32'd1);
        chk("csum_novld", {31'd0, cmd_valid}, 32'd0);
`else
        send_frame(8'h10, 3'd1, 32'h0000_00FF);
        send_byte(8'h00);
`endif
        idle(2);

        send_frame(8'h30, 3'd0, 32'h0);
        idle(1);
        send_frame(8'h40, 3'd4, 32'h4433_2211);
        idle(1);
        send_frame(8'h41, 3'd3, 32'h00CC_BBAA);
        idle(2);

        exp_err.push_back(2'd0);
        send_byte(8'hA5); send_byte(8'h10);
        seen = 1'b0; n_to = 0;
        for (int k = 1; k <= TIMEOUT + 5 && !seen; k++) begin
            @(posedge clk); #1;
            if (err_pulse) begin seen = 1'b1; n_to = k; end
        end
        chk("timeout_seen", {31'd0, seen}, 32'd1);
        chk("timeout_window", {31'd0, (n_to >= TIMEOUT && n_to <= TIMEOUT + 1)}, 32'd1);
        idle(2);
        send_frame(8'h60, 3'd1, 32'h0000_00AB);
        idle(2);

        cmd_ready = 1'b0;
        send_frame(8'h50, 3'd1, 32'h0000_0077);
        idle(2);
        exp_err.push_back(2'd3);
        send_byte(8'h55);
        chk("ovr_pulse", {31'd0, err_pulse}, 32'd1);
        chk("ovr_vld",   {31'd0, cmd_valid}, 32'd1);
        chk("ovr_op",    {24'd0, cmd_op},    32'h50);
        chk("ovr_len",   {29'd0, cmd_len},   32'd1);
        chk("ovr_arg",   cmd_arg,            32'h77);
        @(posedge clk); #1;
        cmd_ready = 1'b1;
        rx_valid  = 1'b1;
        rx_data   = 8'hA5;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        chk("xfer_vld_low", {31'd0, cmd_valid}, 32'd0);
        send_body(8'h51, 3'd0, 32'h0);
        idle(2);

        send_byte(8'hA5); send_byte(8'h10); send_byte(8'h02); send_byte(8'h34);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid_rst_vld",  {31'd0, cmd_valid}, 32'd0);
        chk("mid_rst_op",   {24'd0, cmd_op},    32'd0);
        chk("mid_rst_arg",  cmd_arg,            32'd0);
        chk("mid_rst_len",  {29'd0, cmd_len},   32'd0);
        chk("mid_rst_err",  {31'd0, err_pulse}, 32'd0);
        chk("mid_rst_code", {30'd0, err_code},  32'd0);
        idle(1);
        send_frame(8'h10, 3'd2, 32'h0000_1234);
        idle(4);

        chk("cmd_queue_drained", exp_cmd.size(), 32'd0);
        chk("err_queue_drained", exp_err.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
